// File: rtl/e32_mode_requester_pkg.sv
// rtl/e32_mode_requester_pkg.sv - shared encodings for the E32 mode requester
package e32_mode_requester_pkg;

    typedef enum logic [1:0] {
        MODE_0 = 2'd0,
        MODE_1 = 2'd1,
        MODE_2 = 2'd2,
        MODE_3 = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_FREE = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_WAIT_LOW  = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_e;

endpackage

// File: rtl/e32_mode_requester_sync_2ff.sv
// rtl/e32_mode_requester_sync_2ff.sv - two-flop synchronizer with parameterized reset value
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/e32_mode_requester.sv
// rtl/e32_mode_requester.sv - drives E32 M1/M0 mode pins and tracks AUX handshake per request
module e32_mode_requester
    import e32_mode_requester_pkg::*;
#(
    parameter logic [1:0] DEFAULT_MODE   = 2'd3,
    parameter int         SETTLE_CYCLES  = 16,
    parameter int         AUX_LOW_WINDOW = 64,
    parameter int         TIMEOUT_CYCLES = 20000
) (
    input  logic       internal_clk,
    input  logic       rst_n,
    input  logic       mode_req_valid,
    input  logic [1:0] mode_req,
    output logic       mode_req_ready,
    input  logic       AUX,
    output logic       M0,
    output logic       M1,
    output logic [1:0] cur_mode,
    output logic       mode_done,
    output logic       mode_timeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int LW = $clog2(AUX_LOW_WINDOW + 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [LW-1:0] LOW_LAST = LW'(AUX_LOW_WINDOW - 1);

    logic          aux_s;
    state_e        state_d, state_q;
    logic [1:0]    pins_d, pins_q;
    logic [1:0]    target_d, target_q;
    logic          leave_d, leave_q;
    logic [TW-1:0] tmo_d, tmo_q;
    logic [SW-1:0] settle_d, settle_q;
    logic [LW-1:0] low_d, low_q;
    logic          done_d, done_q;
    logic          timeout_d, timeout_q;
    logic          tmo_hit;

    sync_2ff #(.RESET_VAL(1'b1)) u_aux_sync (
        .clk   (internal_clk),
        .rst_n (rst_n),
        .d     (AUX),
        .q     (aux_s)
    );

    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pins_q    <= DEFAULT_MODE;
            target_q  <= DEFAULT_MODE;
            leave_q   <= 1'b0;
            tmo_q     <= '0;
            settle_q  <= '0;
            low_q     <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pins_q    <= pins_d;
            target_q  <= target_d;
            leave_q   <= leave_d;
            tmo_q     <= tmo_d;
            settle_q  <= settle_d;
            low_q     <= low_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pins_d    = pins_q;
        target_d  = target_q;
        leave_d   = leave_q;
        tmo_d     = tmo_q;
        settle_d  = settle_q;
        low_d     = low_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        tmo_hit   = (tmo_q == TMO_LAST);

        if (state_q != ST_IDLE && tmo_q < TMO_MAX) begin
            tmo_d = tmo_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (mode_req_valid) begin
                    if (mode_req == pins_q) begin
                        done_d = 1'b1;
                    end else begin
                        target_d = mode_req;
                        leave_d  = (pins_q == MODE_3) && (mode_req != MODE_3);
                        tmo_d    = '0;
                        state_d  = ST_WAIT_FREE;
                    end
                end
            end
            ST_WAIT_FREE: begin
                if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (aux_s) begin
                    pins_d   = target_q;
                    settle_d = '0;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (settle_q == SET_LAST) begin
                    low_d   = '0;
                    state_d = leave_q ? ST_WAIT_LOW : ST_WAIT_HIGH;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_WAIT_LOW: begin
                // A missed low pulse is tolerated: the window just falls through to WAIT_HIGH.
                if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (!aux_s || low_q == LOW_LAST) begin
                    state_d = ST_WAIT_HIGH;
                end else begin
                    low_d = low_q + 1'b1;
                end
            end
            ST_WAIT_HIGH: begin
                // Completion outranks a simultaneous timeout.
                if (aux_s) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mode_req_ready = (state_q == ST_IDLE);
        M1             = pins_q[1];
        M0             = pins_q[0];
        cur_mode       = pins_q;
        mode_done      = done_q;
        mode_timeout   = timeout_q;
    end

endmodule

// File: doc/e32_mode_requester.md
E32_MODE_REQUESTER -- requirements
Module: e32_mode_requester

Interface
REQ-001 Parameter DEFAULT_MODE, 2'd3, mode driven on M1/M0 after reset.
REQ-002 Parameter SETTLE_CYCLES, 16, clock cycles M1/M0 are held before AUX is sampled after a pin change.
REQ-003 Parameter AUX_LOW_WINDOW, 64, cycles allowed for AUX to fall when leaving mode 3.
REQ-004 Parameter TIMEOUT_CYCLES, 20000, maximum cycles from request acceptance to completion.
REQ-005 Clocking: one clock; reset is asynchronous and active-low. Ports internal_clk (input, 1, sole clock) and rst_n (input, 1, asynchronous active-low reset).
REQ-006 mode_req_valid  input  1  host requests a mode change.
REQ-007 mode_req  input  2  requested mode {M1,M0}.
REQ-008 mode_req_ready  output  1  high only in IDLE; the request is accepted on valid&ready.
REQ-009 AUX  input  1  transceiver busy/ready line, asynchronous, high = free.
REQ-010 M0, M1  output  1 each  mode pins driven to the transceiver, registered.
REQ-011 cur_mode  output  2  last mode driven on {M1,M0}.
REQ-012 mode_done  output  1  one-cycle pulse on successful completion.
REQ-013 mode_timeout  output  1  one-cycle pulse on timeout expiry.

Function
REQ-014 AUX SHALL pass through a 2-flop synchronizer (aux_s) before any use; synchronizer reset value 1.
REQ-015 States SHALL be IDLE, WAIT_FREE, SETTLE, WAIT_LOW and WAIT_HIGH.
REQ-016 IDLE: on valid&ready with mode_req==cur_mode, the block SHALL pulse mode_done on the next cycle, stay in IDLE and leave the pins unchanged.
REQ-017 IDLE: on valid&ready with mode_req!=cur_mode, the block SHALL latch the target and the leaving-standby flag (cur_mode==3 && target!=3), clear the timeout counter and go to WAIT_FREE.
REQ-018 WAIT_FREE: when aux_s==1, on the same edge the block SHALL drive {M1,M0} and cur_mode to the target, clear the settle counter and go to SETTLE.
REQ-019 SETTLE: after SETTLE_CYCLES cycles, the block SHALL go to WAIT_LOW if leaving-standby, otherwise to WAIT_HIGH.
REQ-020 WAIT_LOW: on aux_s==0 the block SHALL go to WAIT_HIGH; if AUX_LOW_WINDOW cycles elapse with aux_s still 1, it SHALL go to WAIT_HIGH (tolerated, no error).
REQ-021 WAIT_HIGH: on aux_s==1 the block SHALL pulse mode_done for one cycle and return to IDLE.
REQ-022 The timeout counter SHALL run in every non-IDLE state. Upon reaching TIMEOUT_CYCLES it SHALL pulse mode_timeout and return to IDLE.
REQ-023 On timeout from WAIT_FREE, pins and cur_mode SHALL be unchanged. On timeout from later states, pins and cur_mode SHALL keep the target.
REQ-024 If timeout expiry and AUX completion occur in the same cycle, completion SHALL win; mode_done and mode_timeout SHALL never be high together.
REQ-025 mode_req_valid outside IDLE SHALL be ignored; requests are not queued.
REQ-026 Counter widths SHALL be $clog2(param+1), saturating, with no wrap-around.

Reset
REQ-027 On rst_n low: {M1,M0}=cur_mode=DEFAULT_MODE, state IDLE, counters 0, mode_done=mode_timeout=0, mode_req_ready=1 after release, synchronizer=1.
REQ-028 Reset asserted mid-operation SHALL abort immediately with no done/timeout pulse.

Structure
REQ-029 Shared package: mode encodings MODE_0..MODE_3 and state encodings.
REQ-030 One sub-module: sync_2ff (2-flop synchronizer with a parameterized reset value).

Verification
REQ-031 Reset with DEFAULT_MODE=3 -> M1=1, M0=1, cur_mode=3, ready=1, no pulses.
REQ-032 Request mode 0 from 3, AUX high -> pins 00 one cycle after the WAIT_FREE entry cycle. Then drive AUX low 5 cycles after SETTLE and high 100 cycles later -> mode_done pulse 3 cycles after AUX rises (2 synchronizer + 1).
REQ-033 Request mode 1 from 0 while AUX stays low 50 cycles -> pins unchanged until aux_s==1, then 01; after SETTLE the block goes straight to WAIT_HIGH; done follows.
REQ-034 Request the current mode (2 when cur_mode=2) -> mode_done next cycle, pins unchanged, ready stays 1.
REQ-035 AUX held low permanently, TIMEOUT_CYCLES=200 -> mode_timeout exactly 200 cycles after acceptance, pins unchanged, back to IDLE.
REQ-036 rst_n pulsed during WAIT_HIGH -> pins return to DEFAULT_MODE, no done/timeout, and a new request is accepted after release.
